// File: rtl/sig_pkg.sv
// Shared types and constants for the self-test signature checker.
package sig_pkg;

  localparam int unsigned STIM_W  = 8;
  localparam int unsigned SIG_W   = 16;
  localparam int unsigned LAT_W   = 2;
  localparam int unsigned PHASE_W = 9;
  localparam logic [STIM_W-1:0] STIM_FULL = 8'hFF;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_FLUSH = 2'd2,
    STATE_DONE  = 2'd3
  } state_e;

  // One compaction step: scramble, add into the low byte, rotate left by one.
  function automatic logic [SIG_W-1:0] compact_step(input logic [SIG_W-1:0]  acc,
                                                    input logic [STIM_W-1:0] seed,
                                                    input logic [STIM_W-1:0] resp);
    logic [STIM_W-1:0] add;
    add = acc[7:0] + (seed ^ resp);
    return {acc[14:8], add, acc[15]};
  endfunction

endpackage

// File: rtl/sig_compactor.sv
// Signature accumulator: cleared by init, folds one response per enabled cycle.
module sig_compactor
  import sig_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              init,
  input  logic              en,
  input  logic [STIM_W-1:0] seed,
  input  logic [STIM_W-1:0] resp,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = compact_step(sig_q, seed, resp);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/signature_checker.sv
// Self-test checker: drives a count stimulus, compacts the delayed response
// into a signature and reports busy/done/pass.
module signature_checker
  import sig_pkg::*;
#(
  parameter int unsigned RESP_LAT = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [STIM_W-1:0] seed,
  input  logic [SIG_W-1:0]  expected_sig,
  input  logic [STIM_W-1:0] cct_resp,
  output logic [STIM_W-1:0] stim_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  state_e               state_q, state_d;
  logic [STIM_W-1:0]    stim_q, stim_d;
  logic [STIM_W-1:0]    seed_q, seed_d;
  logic [SIG_W-1:0]     exp_q, exp_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 init_c, en_c, go_done_c, active_c;
  logic [SIG_W-1:0]     sig_c;

  // Compaction window: 255 cycles, shifted RESP_LAT cycles after RUN entry.
  assign active_c = (state_q == STATE_RUN) || (state_q == STATE_FLUSH);
  assign en_c     = active_c
                 && (phase_q >= PHASE_W'(RESP_LAT))
                 && (phase_q <  PHASE_W'(RESP_LAT + 255));

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    seed_d    = seed_q;
    exp_d     = exp_q;
    lat_cnt_d = lat_cnt_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    init_c    = 1'b0;
    go_done_c = 1'b0;

    if (active_c) begin
      phase_d = phase_q + PHASE_W'(1);
    end

    unique case (state_q)
      STATE_IDLE, STATE_DONE: begin
        if (start) begin
          state_d   = STATE_RUN;
          stim_d    = '0;
          seed_d    = seed;
          exp_d     = expected_sig;
          lat_cnt_d = '0;
          phase_d   = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          init_c    = 1'b1;
        end
      end
      STATE_RUN: begin
        if (stim_q == STIM_FULL) begin
          if (RESP_LAT == 0) begin
            go_done_c = 1'b1;
          end else begin
            state_d   = STATE_FLUSH;
            lat_cnt_d = LAT_W'(1);
          end
        end else begin
          stim_d = stim_q + STIM_W'(1);
        end
      end
      STATE_FLUSH: begin
        if (lat_cnt_q == LAT_W'(RESP_LAT)) begin
          go_done_c = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
    endcase

    // The last compaction lands on the edge before DONE entry, so sig_c is final here.
    if (go_done_c) begin
      state_d = STATE_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (sig_c == exp_q);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= STATE_IDLE;
      stim_q    <= '0;
      seed_q    <= '0;
      exp_q     <= '0;
      lat_cnt_q <= '0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      seed_q    <= seed_d;
      exp_q     <= exp_d;
      lat_cnt_q <= lat_cnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  sig_compactor u_compactor (
    .clk   (clk),
    .clear (clear),
    .init  (init_c),
    .en    (en_c),
    .seed  (seed_q),
    .resp  (cct_resp),
    .sig   (sig_c)
  );

  assign stim_out  = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_c;

endmodule

// File: tb/tb_signature_checker.sv
// Directed bench for signature_checker: one instance with zero response
// latency and one with a two-cycle delayed identity response.
module tb_signature_checker;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic [15:0] expected_sig = 16'h0000;
  logic [7:0]  resp0, resp2, stim0, stim2, d1, d2;
  logic        busy0, done0, pass0, busy2, done2, pass2;
  logic [15:0] sig0, sig2;
  bit          ident = 1'b1;
  bit          flip = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signature_checker #(.RESP_LAT(0)) dut0 (
    .clk(clk), .clear(clear), .start(start), .seed(seed), .expected_sig(expected_sig),
    .cct_resp(resp0), .stim_out(stim0), .busy(busy0), .done(done0), .pass(pass0),
    .signature(sig0)
  );

  signature_checker #(.RESP_LAT(2)) dut2 (
    .clk(clk), .clear(clear), .start(start), .seed(seed), .expected_sig(expected_sig),
    .cct_resp(resp2), .stim_out(stim2), .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2)
  );

  // Circuit under test models: combinational for dut0, two-cycle delay for dut2.
  assign resp0 = ident ? stim0 : ((flip && stim0 == 8'h80) ? 8'h01 : 8'h00);
  always @(posedge clk) begin
    d1 <= stim2;
    d2 <= d1;
  end
  assign resp2 = d2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] sd, input bit id, input bit fl);
    logic [15:0] acc;
    logic [7:0]  r, add;
    acc = 16'h0000;
    for (int i = 0; i < 255; i++) begin
      r   = id ? 8'(i) : ((fl && i == 128) ? 8'h01 : 8'h00);
      add = acc[7:0] + (sd ^ r);
      acc = {acc[14:8], add, acc[15]};
    end
    return acc;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges including the start edge until each done rises.
  task automatic wait_done(input bit early, input bit mid, output int n0, output int n2);
    int n;
    logic [7:0] keep;
    n = 1; n0 = 0; n2 = 0;
    keep = seed;
    while (!(n0 != 0 && n2 != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (early && n == 2) check_eq("sig_edge1", sig0, 16'h0154);
      if (early && n == 3) check_eq("sig_edge2", sig0, 16'h03FE);
      if (mid && n == 50) begin start = 1'b1; seed = 8'h55; end
      if (mid && n == 51) begin start = 1'b0; seed = keep; end
      if (mid && n == 52) check_eq("start_in_run_ignored", stim0, 8'h33);
      if (done0 && n0 == 0) n0 = n;
      if (done2 && n2 == 0) n2 = n;
    end
  endtask

  logic [15:0] m_aa, m_b8, m_b8f, held;
  int n0, n2;

  initial begin
    m_aa  = model(8'hAA, 1'b1, 1'b0);
    m_b8  = model(8'hB8, 1'b0, 1'b0);
    m_b8f = model(8'hB8, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs", {stim0, sig0, busy0, done0, pass0}, 32'h0);
    @(negedge clk) clear = 1'b1;

    // Reset mid-RUN aborts immediately.
    seed = 8'hAA; expected_sig = m_aa; ident = 1'b1;
    pulse_start();
    repeat (39) @(posedge clk);
    #1;
    check_eq("run_stim39", {busy0, stim0}, {1'b1, 8'h27});
    #2 clear = 1'b0;
    #1;
    check_eq("midrun_clear", {stim0, sig0, busy0, done0, pass0}, 32'h0);
    check_eq("midrun_clear_lat2", {stim2, sig2, busy2, done2, pass2}, 32'h0);
    @(negedge clk) clear = 1'b1;

    // Identity response, both latencies in parallel.
    pulse_start();
    wait_done(1'b1, 1'b0, n0, n2);
    check_eq("done_edge_lat0", n0, 257);
    check_eq("done_edge_lat2", n2, 259);
    check_eq("sig_identity", sig0, m_aa);
    check_eq("sig_identity_lat2", sig2, m_aa);
    check_eq("done_state", {busy0, done0, pass0, stim0}, {3'b011, 8'hFF});
    check_eq("pass_lat2", {busy2, done2, pass2}, 3'b011);

    // Off-by-one golden value must fail.
    expected_sig = m_aa ^ 16'h0001;
    pulse_start();
    wait_done(1'b0, 1'b0, n0, n2);
    check_eq("badgold_done", {done0, pass0}, 2'b10);
    check_eq("badgold_sig", sig0, m_aa);

    // Constant zero response with seed B8, then one flipped bit.
    ident = 1'b0; seed = 8'hB8; expected_sig = m_b8;
    pulse_start();
    wait_done(1'b0, 1'b0, n0, n2);
    check_eq("const_sig", sig0, m_b8);
    check_eq("const_pass", {done0, pass0}, 2'b11);
    flip = 1'b1;
    pulse_start();
    wait_done(1'b0, 1'b0, n0, n2);
    check_eq("flip_sig", sig0, m_b8f);
    check_eq("flip_pass", {done0, pass0}, 2'b10);

    // Start during RUN ignored; start in DONE restarts cleanly.
    ident = 1'b1; flip = 1'b0; seed = 8'hAA; expected_sig = m_aa;
    pulse_start();
    check_eq("restart_clears", {busy0, done0, pass0, stim0, sig0}, {3'b100, 8'h00, 16'h0000});
    wait_done(1'b0, 1'b1, n0, n2);
    check_eq("midstart_done_edge", n0, 257);
    check_eq("midstart_sig", sig0, m_aa);
    check_eq("midstart_pass", pass0, 1'b1);
    held = sig0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("done_holds", {done0, pass0, sig0}, {2'b11, held});
    pulse_start();
    wait_done(1'b0, 1'b0, n0, n2);
    check_eq("rerun_done_edge", n0, 257);
    check_eq("rerun_sig", sig0, held);
    check_eq("rerun_pass", {done0, pass0}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
